// File: rtl/xor5_parity_checker.sv
// -----------------------------------------------------------------------------
// xor5_parity_checker
//
// Receive side of the XOR parity link. Collects a bit-serial frame of DATA_W
// data bits (LSB first) followed by one parity bit, rebuilds the data word,
// checks even overall parity and hands the word plus an error flag to a
// word-level consumer through a one-entry valid/ready output buffer. A
// saturating counter tracks how many frames arrived with bad parity.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   serial bit present
//   in_ready   checker can accept a bit this cycle (combinational on out_ready)
//   in_bit     serial data bit, LSB first, parity bit last
//   in_sof     marks in_bit as the first bit of a frame
//   out_valid  reassembled word available
//   out_ready  consumer accepts the word
//   out_data   reassembled data word (parity bit never stored here)
//   out_perr   1 = XOR of all DATA_W+1 received bits is 1
//   err_count  number of frames with out_perr=1, saturating at all-ones
// -----------------------------------------------------------------------------
module xor5_parity_checker #(
    parameter int DATA_W    = 5,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_bit,
    input  logic                 in_sof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_perr,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Counter must reach DATA_W (the parity-bit position).
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [DATA_W-1:0]      shreg_q,     shreg_d;
    logic                   par_q,       par_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_W-1:0]      out_data_q,  out_data_d;
    logic                   out_perr_q,  out_perr_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q,   err_cnt_d;

    logic accept;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(
        input logic [ERR_CNT_W-1:0] val,
        input logic                 inc
    );
        if (inc && (val != {ERR_CNT_W{1'b1}}))
            return val + ERR_CNT_W'(1);
        return val;
    endfunction

    // A full, unconsumed output buffer stalls the serial input; every piece of
    // frame state therefore only moves on an accepted bit.
    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_perr_d  = out_perr_q;
        err_cnt_d   = err_cnt_q;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        if (accept) begin
            if (in_sof) begin
                // Start of frame, from IDLE or as a resync mid-frame: any
                // partial word is dropped silently.
                shreg_d    = '0;
                shreg_d[0] = in_bit;
                par_d      = in_bit;
                cnt_d      = CNT_W'(1);
                state_d    = RECV;
            end else if (state_q == RECV) begin
                if (cnt_q == CNT_W'(DATA_W)) begin
                    // Parity bit: publish the word; a frame completing here
                    // overwrites a word being consumed on this same edge.
                    out_data_d  = shreg_q;
                    out_perr_d  = par_q ^ in_bit;
                    out_valid_d = 1'b1;
                    err_cnt_d   = sat_inc(err_cnt_q, par_q ^ in_bit);
                    shreg_d     = '0;
                    par_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    for (int i = 1; i < DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i))
                            shreg_d[i] = in_bit;
                    end
                    par_d = par_q ^ in_bit;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // IDLE without in_sof: stray bit, dropped.
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_perr_q  <= out_perr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_perr  = out_perr_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_xor5_parity_checker.sv
// -----------------------------------------------------------------------------
// Bench for xor5_parity_checker. Two instances share the stimulus: dut uses an
// 8-bit error counter, dut2 a 2-bit one for the saturation sequence.
// -----------------------------------------------------------------------------
module tb_xor5_parity_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_bit, in_sof, out_ready;
    logic       in_ready, out_valid, out_perr;
    logic [4:0] out_data;
    logic [7:0] err_count;
    logic       in_ready2, out_valid2, out_perr2;
    logic [4:0] out_data2;
    logic [1:0] err_count2;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out  = 0;
    logic [4:0] last_data;
    logic       last_perr;

    always #5 clk = ~clk;

    xor5_parity_checker #(.DATA_W(5), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_bit(in_bit), .in_sof(in_sof), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_perr(out_perr),
        .err_count(err_count)
    );

    xor5_parity_checker #(.DATA_W(5), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_bit(in_bit), .in_sof(in_sof), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_perr(out_perr2),
        .err_count(err_count2)
    );

    // Count output handshakes of the main instance.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out     <= n_out + 1;
            last_data <= out_data;
            last_perr <= out_perr;
        end
    end

    typedef struct {
        logic [4:0] data;
        logic       parity;
        logic [4:0] exp_data;
        logic       exp_perr;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Present one bit and return 1 time unit after the edge that accepted it.
    task automatic send_bit(input logic sof, input logic b);
        int guard;
        in_valid = 1'b1; in_sof = sof; in_bit = b;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL send_bit_timeout: in_ready %0b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [4:0] d, input logic p);
        for (int i = 0; i < 5; i++) send_bit(i == 0, d[i]);
        send_bit(1'b0, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int base;
        vecs[0] = '{5'b10110, 1'b1, 5'b10110, 1'b0, 8'd0};
        vecs[1] = '{5'b10110, 1'b0, 5'b10110, 1'b1, 8'd1};
        vecs[2] = '{5'b10110, 1'b1, 5'b10110, 1'b0, 8'd1};
        vecs[3] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 8'd1};
        vecs[4] = '{5'b11111, 1'b1, 5'b11111, 1'b0, 8'd1};
        vecs[5] = '{5'b00001, 1'b0, 5'b00001, 1'b1, 8'd2};
        vecs[6] = '{5'b01010, 1'b0, 5'b01010, 1'b0, 8'd2};

        out_ready = 1'b1;
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_perr",  out_perr,  0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready",  in_ready,  1);

        // Table of frames, consumer always ready.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].parity);
            check($sformatf("vec%0d_valid", v), out_valid, 1);
            check($sformatf("vec%0d_data", v),  out_data,  vecs[v].exp_data);
            check($sformatf("vec%0d_perr", v),  out_perr,  vecs[v].exp_perr);
            check($sformatf("vec%0d_cnt", v),   err_count, vecs[v].exp_cnt);
        end
        idle(1);
        check("vec_drained", out_valid, 0);

        // Backpressure: frame 1 held, frame 2 stalls until consumed.
        do_reset();
        out_ready = 1'b0;
        base = n_out;
        send_frame(5'b10110, 1'b1);
        check("bp_valid",    out_valid, 1);
        check("bp_in_ready", in_ready,  0);
        in_valid = 1'b1; in_sof = 1'b1; in_bit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_stall%0d_ready", i), in_ready, 0);
            check($sformatf("bp_stall%0d_data", i),  out_data, 5'b10110);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        check("bp_consumed", out_valid, 0);
        check("bp_first_word", last_data, 5'b10110);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        check("bp_f2_valid", out_valid, 1);
        check("bp_f2_data",  out_data,  5'b01101);
        check("bp_f2_perr",  out_perr,  0);
        idle(2);
        check("bp_n_out", n_out - base, 2);

        // Resync: partial frame then a new sof frame -> one word.
        do_reset();
        base = n_out;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_frame(5'b11111, 1'b1);
        idle(2);
        check("rs_n_out", n_out - base, 1);
        check("rs_data",  last_data, 5'b11111);
        check("rs_perr",  last_perr, 0);
        check("rs_cnt",   err_count, 0);
        // Stray bits while IDLE.
        base = n_out;
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'(i));
        idle(2);
        check("stray_n_out", n_out - base, 0);
        check("stray_valid", out_valid, 0);

        // Saturation on the 2-bit counter instance.
        do_reset();
        for (int f = 0; f < 5; f++) begin
            send_frame(5'b00000, 1'b1);
            check($sformatf("sat%0d_perr", f), out_perr2, 1);
            check($sformatf("sat%0d_cnt", f),  err_count2, (f < 3) ? f + 1 : 3);
        end

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_valid", out_valid, 0);
        check("mr_data",  out_data,  0);
        check("mr_perr",  out_perr,  0);
        check("mr_cnt",   err_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        base = n_out;
        send_frame(5'b00001, 1'b1);
        idle(2);
        check("mr_n_out", n_out - base, 1);
        check("mr_word",  last_data, 5'b00001);
        check("mr_perr2", last_perr, 0);
        check("mr_cnt2",  err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xor5_parity_checker.md
Name: xor5_parity_checker

Overview:
- Receive-side counterpart of the 5-input XOR parity generator. The generator emits parity = XOR of the data bits.
- This block takes a bit-serial frame of DATA_W data bits followed by one parity bit, then reassembles the data word.
- It checks even overall parity, presents the word plus an error flag on a valid/ready output, and keeps a saturating error count.
- It sits between the serial link and the word-level consumer.

Parameters:
- DATA_W, 5, data bits per frame (frame length = DATA_W+1 bits, parity last).
- ERR_CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  serial bit present.
- in_ready  output  1  checker can accept a bit this cycle.
- in_bit  input  1  serial data; LSB first, parity bit last.
- in_sof  input  1  qualifies in_bit as the first bit of a frame.
- out_valid  output  1  reassembled word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  reassembled data word.
- out_perr  output  1  1 = parity error (XOR of all DATA_W+1 received bits is 1).
- err_count  output  ERR_CNT_W  number of frames with out_perr=1, saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, bit counter=0, shift register=0, running parity=0.
  - out_valid=0, out_data=0, out_perr=0, err_count=0.
  - A partial frame in progress is discarded and nothing is output for it.
- Handshake:
  - A bit is accepted when in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready). This is combinational from out_ready.
  - In IDLE, in_ready is also high, but accepted bits without in_sof are dropped.
- States:
  - IDLE:
    - An accepted bit with in_sof=1 stores the bit at data index 0, sets parity=in_bit and count=1, then goes to RECV.
    - Accepted bits with in_sof=0 are ignored.
  - RECV, count < DATA_W:
    - An accepted bit goes to data index count; parity ^= bit; count++.
  - RECV, count == DATA_W (the parity bit):
    - At that edge: out_data=shift register, out_perr=parity^bit, out_valid=1, state=IDLE, count=0.
    - err_count += out_perr, saturating at 2^ERR_CNT_W-1 (holds at max, no wrap).
  - RECV, accepted bit with in_sof=1:
    - Resync. The partial frame is discarded with no output and no error count.
    - The bit is treated as the first bit of a new frame (count=1).
- Latency: out_valid rises on the clock edge that accepts the parity bit, one cycle after that bit is presented.
- Output buffer (one entry):
  - out_data and out_perr are held stable while out_valid && !out_ready.
  - out_valid clears on the edge where out_valid && out_ready, unless a new frame completes at the same edge; then the new word replaces the old one and out_valid stays 1.
- No bit is lost under backpressure: in_ready=0 stalls the counter, shift register and parity.
- in_valid=0 cycles mid-frame are gaps: all state is held, with no timeout.
- The shift register holds only data bits; the parity bit is never stored in out_data.

Test Plan:
1. Good frame: after reset, send bits 0,1,1,0,1 (sof on the first) then parity 1, with out_ready=1 -> one cycle later out_valid=1, out_data=5'b10110, out_perr=0, err_count=0.
2. Bad parity: same data with parity 0 -> out_data=5'b10110, out_perr=1, err_count=1. A following good frame leaves err_count=1.
3. Backpressure: hold out_ready=0 after frame 1 completes, then stream frame 2 ->
   - in_ready=0 from the edge out_valid rises; frame 2 bits stall.
   - out_data stays 5'b10110.
   - Raise out_ready -> frame 1 is consumed; frame 2 completes later with the correct word.
4. Resync and stray bits:
   - 3 bits of a frame, then a bit with in_sof=1 followed by a full valid frame 11111+parity 1 -> exactly one output: out_data=5'b11111, out_perr=0.
   - Bits sent with in_sof=0 while IDLE -> no output.
5. Saturation: ERR_CNT_W=2, send 5 bad-parity frames -> err_count goes 1,2,3,3,3.
6. Reset mid-frame: assert rst after 4 bits of a frame, then send a full valid frame 5'b00001 with parity 1 -> all outputs 0 during reset; afterwards exactly one output, out_data=5'b00001, out_perr=0, err_count=0.
